// File: rtl/hilo_muldiv.sv
// HI/LO multiply-divide unit: single-cycle MULT/MULTU and a 32-step restoring
// divider for DIV/DIVU, with MTHI/MTLO writes, pipeline flush and done pulse.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | accepts MULT/MULTU (written same edge), DIV issue, MTHI/MTLO
// S_DIV  | one restoring step per edge, cnt counts completed steps
module hilo_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        we_hi,
    input  logic        we_lo,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DIV  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [5:0]  cnt;
    logic [31:0] dvs;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        neg_q;
    logic        neg_r;
    logic        dz;

    logic        issue;
    logic        issue_mul;
    logic        issue_div;
    logic        last_step;
    logic        commit;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] rem_sh;
    logic [32:0] diff;
    logic        step_ok;
    logic [31:0] rem_step;
    logic [31:0] quo_step;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    // Issue qualification, multiplier, one restoring step and result fix-up.
    always_comb begin
        issue     = (state == S_IDLE) && start && !flush;
        issue_mul = issue && !op[1];
        issue_div = issue && op[1];
        last_step = (state == S_DIV) && (cnt == 6'd31);
        commit    = last_step && !flush;

        // MULTU zero-extends, MULT sign-extends; the low 64 bits of an
        // unsigned product of the extended operands are correct for both.
        ext_a   = op[0] ? {32'd0, a} : {{32{a[31]}}, a};
        ext_b   = op[0] ? {32'd0, b} : {{32{b[31]}}, b};
        product = ext_a * ext_b;

        a_abs = (!op[0] && a[31]) ? (32'd0 - a) : a;
        b_abs = (!op[0] && b[31]) ? (32'd0 - b) : b;

        // Dividend bits are shifted out of the top of quo while quotient
        // bits are shifted into the bottom.
        rem_sh   = {rem, quo[31]};
        diff     = rem_sh - {1'b0, dvs};
        step_ok  = !diff[32];
        rem_step = step_ok ? diff[31:0] : rem_sh[31:0];
        quo_step = {quo[30:0], step_ok};

        // Divide by zero yields all-ones quotient; the remainder then equals
        // |a| and the sign fix-up restores the raw dividend.
        q_fix = dz ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - quo_step) : quo_step);
        r_fix = neg_r ? (32'd0 - rem_step) : rem_step;

        busy = issue_div || (state == S_DIV);
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (issue_div) state_nx = S_DIV;
            S_DIV:  if (flush || last_step) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Divider datapath, iteration counter and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= 6'd0;
            dvs   <= 32'd0;
            quo   <= 32'd0;
            rem   <= 32'd0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz    <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= commit;
            if (issue_div) begin
                cnt   <= 6'd0;
                dvs   <= b_abs;
                quo   <= a_abs;
                rem   <= 32'd0;
                neg_q <= !op[0] && (a[31] ^ b[31]);
                neg_r <= !op[0] && a[31];
                dz    <= (b == 32'd0);
            end else if (state == S_DIV) begin
                cnt <= cnt + 6'd1;
                quo <= quo_step;
                rem <= rem_step;
            end
        end
    end

    // HI/LO registers: multiply, divide commit, or MTHI/MTLO when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (issue_mul) begin
            hi <= product[63:32];
            lo <= product[31:0];
        end else if (commit) begin
            hi <= r_fix;
            lo <= q_fix;
        end else if ((state == S_IDLE) && !start) begin
            if (we_hi) hi <= wdata;
            if (we_lo) lo <= wdata;
        end
    end

endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 start  input  1  EX-stage mult/div issue strobe, qualified by op.
REQ-004 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 a  input  32  rs operand / dividend.
REQ-006 b  input  32  rt operand / divisor.
REQ-007 we_hi  input  1  MTHI write enable.
REQ-008 we_lo  input  1  MTLO write enable.
REQ-009 wdata  input  32  MTHI/MTLO data.
REQ-010 flush  input  1  pipeline flush; aborts an in-flight divide.
REQ-011 hi  output  32  HI register, registered.
REQ-012 lo  output  32  LO register, registered.
REQ-013 busy  output  1  stall request to the hazard unit.
REQ-014 done  output  1  one-cycle pulse when a divide commits.

Function
REQ-015 States: IDLE, DIV; 6-bit iteration counter cnt.
REQ-016 MULT/MULTU, IDLE, start=1: 64-bit product written at the same edge; HI=product[63:32], LO=product[31:0]; busy=0; done=0.
REQ-017 MULT sign-extends a and b to 64 bits; MULTU zero-extends them.
REQ-018 DIV/DIVU, IDLE, start=1 (cycle 0): busy=1 combinationally; edge latches |a|, |b| (DIV) or a, b (DIVU) and the sign flags; cnt=0; state->DIV.
REQ-019 DIV state: one restoring-division step per edge, shift remainder left 1, subtract divisor, keep the result if non-negative and set the quotient bit; cnt increments.
REQ-020 After the 32nd step (the edge ending cycle 32): sign-corrected result written, LO=quotient, HI=remainder; state->IDLE.
REQ-021 busy=1 in cycles 0..32 inclusive (33 cycles); done=1 in cycle 33 only.
REQ-022 Signed fix-up: quotient negated when sign(a)!=sign(b); remainder takes the sign of a.
REQ-023 0x80000000 / 0xFFFFFFFF (DIV): LO=0x80000000, HI=0.
REQ-024 Divide by zero: normal 33-cycle latency; LO=0xFFFFFFFF; HI=a (raw dividend); no exception.
REQ-025 start in DIV state: ignored.
REQ-026 IDLE, no start: we_hi writes wdata to HI and we_lo writes wdata to LO at the edge; both may be asserted together.
REQ-027 start and we_hi/we_lo in the same cycle: start wins; the write is dropped.
REQ-028 we_hi/we_lo in DIV state: ignored.
REQ-029 flush=1 in DIV state: state->IDLE at that edge; hi/lo unchanged; done stays 0; busy=0 from the next cycle.
REQ-030 flush=1 with start in IDLE: the operation is not started; MULT does not write.
REQ-031 hi/lo hold their value whenever no write condition applies.

Reset
REQ-032 rst=1 at an edge: hi=0, lo=0, state=IDLE, cnt=0, done=0; busy=0 from the next cycle.
REQ-033 rst has priority over flush, start and writes, including mid-divide; a partial result is never written.

Verification
REQ-034 MULT a=0xFFFFFFFD, b=5 -> next cycle HI=0xFFFFFFFF, LO=0xFFFFFFF1; busy never 1.
REQ-035 DIVU a=100, b=7 -> busy 33 cycles; done in cycle 33; LO=14, HI=2.
REQ-036 DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-037 DIVU a=0x1234, b=0 -> after 33 cycles LO=0xFFFFFFFF, HI=0x1234.
REQ-038 HI=0xAA preloaded via we_hi; start DIV; flush in cycle 10 -> HI=0xAA, no done, busy=0 in cycle 11; rst in cycle 5 of a second divide -> hi=lo=0.
REQ-039 we_lo=1, wdata=0x55 with MULTU 3*4 in the same cycle -> LO=12, HI=0.
